// File: rtl/dp_sched.sv
// rtl/dp_sched.sv - start/done sequencer for one dp_core: per-split NTT then MADD passes with a wait-state watchdog
module dp_sched #(
  parameter int NUM_SPLIT = 4,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [1:0] i_num_split,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic       o_ntt_start,
  input  logic       i_ntt_done,
  output logic       o_madd_start,
  input  logic       i_madd_done,
  output logic [1:0] o_idx_split
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NTT_GO    = 3'd1,
    NTT_WAIT  = 3'd2,
    MADD_GO   = 3'd3,
    MADD_WAIT = 3'd4
  } state_t;

  localparam logic [1:0]           MAX_SPLIT = 2'(NUM_SPLIT - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT);
  localparam logic                 WD_EN     = (TIMEOUT != 0);

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           idx_q, idx_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ntt_start_q, ntt_start_d;
  logic                 madd_start_q, madd_start_d;
  logic                 ntt_prev_q, madd_prev_q;

  logic                 ntt_ev, madd_ev, timeout_hit;
  logic [TIMEOUT_W-1:0] cnt_inc;

  // A level already high when a wait begins never produces an event.
  assign ntt_ev      = i_ntt_done & ~ntt_prev_q;
  assign madd_ev     = i_madd_done & ~madd_prev_q;
  assign cnt_inc     = cnt_q + TIMEOUT_W'(1);
  assign timeout_hit = WD_EN && (cnt_inc == TIMEOUT_V);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          last_d  = (i_num_split > MAX_SPLIT) ? MAX_SPLIT : i_num_split;
          idx_d   = 2'd0;
          err_d   = 1'b0;
          state_d = NTT_GO;
        end
      end
      NTT_GO: begin
        cnt_d   = '0;
        state_d = NTT_WAIT;
      end
      NTT_WAIT: begin
        if (ntt_ev) begin
          state_d = MADD_GO;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MADD_GO: begin
        cnt_d   = '0;
        state_d = MADD_WAIT;
      end
      MADD_WAIT: begin
        if (madd_ev) begin
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = NTT_GO;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in the state's own cycle.
    busy_d       = (state_d != IDLE);
    ntt_start_d  = (state_d == NTT_GO);
    madd_start_d = (state_d == MADD_GO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 2'd0;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ntt_start_q  <= 1'b0;
      madd_start_q <= 1'b0;
      ntt_prev_q   <= 1'b0;
      madd_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ntt_start_q  <= ntt_start_d;
      madd_start_q <= madd_start_d;
      ntt_prev_q   <= i_ntt_done;
      madd_prev_q  <= i_madd_done;
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_ntt_start  = ntt_start_q;
  assign o_madd_start = madd_start_q;
  assign o_idx_split  = idx_q;

endmodule

// File: doc/dp_sched.md
# dp_sched

Sequencing controller for one `dp_core` instance. On a single start pulse it runs `NUM_SPLIT`-bounded passes. Each pass issues an NTT start pulse, waits for the NTT done edge, issues a MADD start pulse, then waits for the MADD done edge. The split index is held stable to the datapath for the whole pass. It sits between the top-level host/control FSM and `dp_core`, replacing ad-hoc start/done glue, and adds a watchdog so a hung core cannot stall the top level.

## Interface
- `NUM_SPLIT`, default 4: hardware maximum number of splits; must be 1..4 because `o_idx_split` is 2 bits.
- `TIMEOUT_W`, default 16: watchdog counter width.
- `TIMEOUT`, default 50000: maximum cycles in a wait state; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state.
- `i_start`  in  1  one-cycle start request.
- `i_num_split`  in  2  number of splits minus 1 for this run; sampled with `i_start`; clamped to `NUM_SPLIT-1`.
- `o_busy`  out  1  high from the cycle after an accepted start until done or error.
- `o_done`  out  1  one-cycle pulse when the last split's MADD completes.
- `o_err`  out  1  sticky watchdog error; cleared by the next accepted `i_start`.
- `o_ntt_start`  out  1  one-cycle pulse to `dp_core.ntt_start`.
- `i_ntt_done`  in  1  from `dp_core.ntt_done`; level signal, rising edge = completion.
- `o_madd_start`  out  1  one-cycle pulse to `dp_core.i_madd_start`.
- `i_madd_done`  in  1  from `dp_core.o_madd_done`; level signal, rising edge = completion.
- `o_idx_split`  out  2  to `dp_core.i_idx_split`; current split index.

## Operation
- States: IDLE, NTT_GO, NTT_WAIT, MADD_GO, MADD_WAIT.
- Edge detect: `ntt_prev` and `madd_prev` registers track the inputs every cycle (reset 0). An event is defined as input=1 and prev=0. A done level that is already high when a wait begins is not an event.
- IDLE, with `i_start`=1: latch the clamped `last_split`, set `o_idx_split`=0, clear `o_err`, go to NTT_GO.
- NTT_GO: `o_ntt_start`=1 for exactly this cycle, then go to NTT_WAIT.
- NTT_WAIT: on an NTT done event go to MADD_GO. MADD done events are ignored here; if both events occur in the same cycle, only the NTT event counts.
- MADD_GO: `o_madd_start`=1 for exactly this cycle, then go to MADD_WAIT.
- MADD_WAIT, on a MADD done event:
  - if `o_idx_split`==`last_split`: `o_done`=1 next cycle, go to IDLE;
  - otherwise: `o_idx_split`+=1 and go to NTT_GO.
- `i_start` while not in IDLE is ignored; it has no effect on the run or on `o_err`.
- Watchdog: the counter clears on entry to each WAIT state and increments every WAIT cycle. If the count reaches `TIMEOUT` (≠0) with no event, then next cycle `o_err`=1, `o_busy`=0, state returns to IDLE, and there is no `o_done`. `o_idx_split` holds its value.
- `rst` asserted mid-run: all outputs and state go to reset values immediately, and no `o_done` is emitted.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_err`=0, `o_ntt_start`=0, `o_madd_start`=0, `o_idx_split`=0, state=IDLE.
- All outputs are registered; there are no combinational input-to-output paths.
- `i_start` sampled in cycle T:
  - `o_busy`=1 and `o_ntt_start`=1 at T+1;
  - `o_idx_split` is valid at T+1 and stable until the next split's NTT_GO.
- `i_ntt_done` rises in cycle D: `o_madd_start`=1 at D+1.
- `i_madd_done` rises in cycle E:
  - not the last split: `o_ntt_start`=1 with the incremented `o_idx_split` at E+1;
  - last split: `o_done`=1 and `o_busy`=0 at E+1.
- A new `i_start` is accepted in the cycle `o_done` is high, since state is already IDLE.
- Minimum run length for one split with done responses of 1 cycle: 6 cycles from `i_start` to `o_done`.

## Test plan
- Single split: `i_num_split`=0, NTT done after 10 cycles, MADD done after 5 → exactly one pulse each of `o_ntt_start` and `o_madd_start`, `o_idx_split`=0 throughout, one `o_done`, `o_busy` falls with `o_done`.
- Four splits: `i_num_split`=3 → `o_idx_split` sequences 0,1,2,3; 4 NTT and 4 MADD start pulses, interleaved NTT before MADD; a single `o_done` after the 4th MADD edge.
- Level-held done: hold `i_ntt_done` high from the previous run across a new start → no premature `o_madd_start`; progress occurs only after the input drops low and rises again.
- Watchdog: `TIMEOUT`=20, never assert `i_madd_done` → `o_err`=1 twenty cycles after MADD_WAIT entry, `o_busy`=0, no `o_done`; the next `i_start` clears `o_err` and runs normally.
- Start while busy, plus clamp: pulse `i_start` during NTT_WAIT → no effect. Then `NUM_SPLIT`=2 with `i_num_split`=3 → only splits 0 and 1 run.
- Async reset mid-MADD_WAIT: assert `rst` between clock edges → all outputs 0 immediately; after release the block is IDLE and accepts a new start.
